invcdf_share_arbiter: RTL and testbench

//  Shares one fixed-latency, non-stallable inverse-CDF (Zelen-Severo) datapath among N_REQ QMC lanes.
//  - Round-robin arbitration of lane requests {t, negate}; each lane ID travels in a tag pipe matched to datapath latency.
//  - Results return to a per-lane output FIFO; per-lane credits stop FIFO overflow because the datapath cannot stall.
//  - Sits between the per-dimension sqrt/log front-ends and the path-generation consumers.

---
 rtl/invcdf_share_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_invcdf_share_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invcdf_share_arbiter.sv
// Round-robin share of one fixed-latency, non-stallable inverse-CDF datapath across N_REQ lanes,
// with credit-protected per-lane return FIFOs. Optional checker: define INVCDF_ARB_CHECK_EN.
module invcdf_share_arbiter #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PIPE_LAT  = 12,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_t,
  input  logic [N_REQ-1:0]         req_negate,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     dp_valid_in,
  output logic [WIDTH-1:0]         dp_t,
  output logic                     dp_negate,
  input  logic                     dp_valid_out,
  input  logic [WIDTH-1:0]         dp_z,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ*WIDTH-1:0]   rsp_z,
  input  logic [N_REQ-1:0]         rsp_ready,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned IdW = $clog2(N_REQ);
  localparam int unsigned CrW = $clog2(OUT_DEPTH + 1);
  localparam int unsigned AdW = $clog2(OUT_DEPTH);

  logic [CrW-1:0]   credit_q [N_REQ];
  logic [N_REQ-1:0] elig;
  logic [IdW-1:0]   rr_ptr_q;
  logic [IdW-1:0]   rr_next;
  logic [IdW-1:0]   winner;
  logic             grant;
  logic [WIDTH-1:0] sel_t;
  logic             sel_negate;

  logic [IdW-1:0]      issue_id_q;
  logic [PIPE_LAT-1:0] tag_v_q;
  logic [IdW-1:0]      tag_id_q [PIPE_LAT];
  logic                tag_last_v;
  logic [IdW-1:0]      tag_last_id;

  logic [WIDTH-1:0] mem_q   [N_REQ][OUT_DEPTH];
  logic [AdW-1:0]   wptr_q  [N_REQ];
  logic [AdW-1:0]   rptr_q  [N_REQ];
  logic [CrW-1:0]   count_q [N_REQ];
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] repair;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] && (credit_q[i] != '0);
    end
  end

  // Two passes: lanes at/after the pointer first, then wrap around from lane 0.
  always_comb begin
    grant     = 1'b0;
    winner    = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!grant && elig[i] && (IdW'(i) >= rr_ptr_q)) begin
        grant  = 1'b1;
        winner = IdW'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!grant && elig[i]) begin
        grant  = 1'b1;
        winner = IdW'(i);
      end
    end
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    rr_next = (winner == IdW'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    sel_t      = '0;
    sel_negate = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_t      = sel_t | req_t[i*WIDTH +: WIDTH];
        sel_negate = sel_negate | req_negate[i];
      end
    end
  end

  // The issue register is the head of the tag pipe, so the last stage lines up with dp_valid_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      dp_valid_in <= 1'b0;
      dp_t        <= '0;
      dp_negate   <= 1'b0;
      issue_id_q  <= '0;
      tag_v_q     <= '0;
      for (int unsigned j = 0; j < PIPE_LAT; j++) begin
        tag_id_q[j] <= '0;
      end
    end else begin
      dp_valid_in <= grant;
      if (grant) begin
        rr_ptr_q   <= rr_next;
        dp_t       <= sel_t;
        dp_negate  <= sel_negate;
        issue_id_q <= winner;
      end
      tag_v_q     <= {tag_v_q[PIPE_LAT-2:0], dp_valid_in};
      tag_id_q[0] <= issue_id_q;
      for (int unsigned j = 1; j < PIPE_LAT; j++) begin
        tag_id_q[j] <= tag_id_q[j-1];
      end
    end
  end

  assign tag_last_v  = tag_v_q[PIPE_LAT-1];
  assign tag_last_id = tag_id_q[PIPE_LAT-1];

  always_comb begin
    rsp_z = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      push[i]      = dp_valid_out && tag_last_v && (tag_last_id == IdW'(i));
      rsp_valid[i] = (count_q[i] != '0);
      pop[i]       = rsp_valid[i] && rsp_ready[i];
      rsp_z[i*WIDTH +: WIDTH] = rsp_valid[i] ? mem_q[i][rptr_q[i]] : '0;
    end
  end

`ifdef INVCDF_ARB_CHECK_EN
  logic orphan;
  logic lost;

  assign orphan = dp_valid_out && !tag_last_v;
  assign lost   = tag_last_v && !dp_valid_out;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      repair[i] = lost && (tag_last_id == IdW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (orphan || lost) begin
      err <= 1'b1;
    end
  end
`else
  assign repair = '0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        credit_q[i] <= CrW'(OUT_DEPTH);
        wptr_q[i]   <= '0;
        rptr_q[i]   <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        credit_q[i] <= credit_q[i] + CrW'(pop[i]) + CrW'(repair[i]) - CrW'(req_ready[i]);
        count_q[i]  <= count_q[i] + CrW'(push[i]) - CrW'(pop[i]);
        if (push[i]) begin
          wptr_q[i] <= wptr_q[i] + 1'b1;
        end
        if (pop[i]) begin
          rptr_q[i] <= rptr_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= dp_z;
      end
    end
  end

  assign busy = dp_valid_in | (|tag_v_q) | (|rsp_valid);

  // Per-lane results still owed by the datapath; only feeds the credit invariant check.
  int unsigned inflight [N_REQ];

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      inflight[i] = (dp_valid_in && (issue_id_q == IdW'(i))) ? 1 : 0;
      for (int unsigned j = 0; j < PIPE_LAT; j++) begin
        if (tag_v_q[j] && (tag_id_q[j] == IdW'(i))) begin
          inflight[i] = inflight[i] + 1;
        end
      end
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  for (genvar g = 0; g < N_REQ; g++) begin : g_credit_inv
    a_credit_inv: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(credit_q[g]) + inflight[g] + 32'(count_q[g])) == OUT_DEPTH);
  end

endmodule

// File: tb/tb_invcdf_share_arbiter.sv
// Scoreboard bench for invcdf_share_arbiter: a delay-line datapath model feeds results back,
// grants push expected z per lane, and a monitor pops and compares on every FIFO pop.
module tb_invcdf_share_arbiter;
  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 12;
`ifdef INVCDF_ARB_CHECK_EN
  localparam logic [31:0] ExpErr = 32'd1;
`else
  localparam logic [31:0] ExpErr = 32'd0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_t;
  logic [N-1:0]   req_negate;
  logic [N-1:0]   req_ready;
  logic           dp_valid_in;
  logic [W-1:0]   dp_t;
  logic           dp_negate;
  logic           dp_valid_out;
  logic [W-1:0]   dp_z;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] rsp_z;
  logic [N-1:0]   rsp_ready;
  logic           busy;
  logic           err;
  logic           inject;

  always #5 clk = ~clk;

  invcdf_share_arbiter #(.WIDTH(W), .N_REQ(N), .PIPE_LAT(LAT), .OUT_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_t(req_t), .req_negate(req_negate), .req_ready(req_ready),
    .dp_valid_in(dp_valid_in), .dp_t(dp_t), .dp_negate(dp_negate),
    .dp_valid_out(dp_valid_out), .dp_z(dp_z),
    .rsp_valid(rsp_valid), .rsp_z(rsp_z), .rsp_ready(rsp_ready),
    .busy(busy), .err(err)
  );

  function automatic logic [31:0] model_z(input logic [31:0] t, input logic neg);
    return (neg ? (~t + 32'd1) : t) ^ 32'h0000_5A5A;
  endfunction

  // Datapath stand-in: exactly LAT cycles from dp_valid_in to dp_valid_out, shares rst_n.
  logic [LAT-1:0] sr_v;
  logic [31:0]    sr_z [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_v <= '0;
      for (int j = 0; j < LAT; j++) sr_z[j] <= '0;
    end else begin
      sr_v    <= {sr_v[LAT-2:0], dp_valid_in};
      sr_z[0] <= model_z(dp_t, dp_negate);
      for (int j = 1; j < LAT; j++) sr_z[j] <= sr_z[j-1];
    end
  end
  assign dp_valid_out = sr_v[LAT-1] | inject;
  assign dp_z         = sr_z[LAT-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dp_issues = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (rst_n && dp_valid_in) dp_issues <= dp_issues + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  logic [32:0] pend    [N][$];
  logic [31:0] exp_q   [N][$];
  logic [31:0] rsp_val [N][$];
  int          rsp_cyc [N][$];
  int          gcnt    [N];
  int          glog    [$];
  int          gcyc    [$];

  // Monitor: every FIFO pop is compared against the lane's expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_val[i].push_back(rsp_z[i*W +: W]);
          rsp_cyc[i].push_back(cyc);
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp lane%0d: got %h, expected no result", i, rsp_z[i*W +: W]);
          end else begin
            check($sformatf("rsp_z_lane%0d", i), rsp_z[i*W +: W], exp_q[i].pop_front());
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_t[i*W +: W]    = pend[i][0][31:0];
        req_negate[i]      = pend[i][0][32];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic add_req(input int lane, input logic [31:0] t, input logic neg);
    pend[lane].push_back({neg, t});
    drive();
  endtask

  task automatic tick();
    logic [32:0] item;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i] && pend[i].size() > 0) begin
        item = pend[i].pop_front();
        exp_q[i].push_back(model_z(item[31:0], item[32]));
        gcnt[i]++;
        glog.push_back(i);
        gcyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      rsp_val[i].delete();
      rsp_cyc[i].delete();
      gcnt[i] = 0;
    end
    glog.delete();
    gcyc.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i].delete();
      exp_q[i].delete();
    end
    req_valid = '0;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
  endtask

  function automatic int outstanding();
    int s = 0;
    for (int i = 0; i < N; i++) s += pend[i].size() + exp_q[i].size();
    return s;
  endfunction

  task automatic wait_gcnt(input int lane, input int n, input int budget, input string name);
    int k = 0;
    while (gcnt[lane] < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(gcnt[lane]), 32'(n));
  endtask

  task automatic wait_total(input int n, input int budget, input string name);
    int k = 0;
    while (glog.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(glog.size()), 32'(n));
  endtask

  task automatic drain(input int budget, input string name);
    int k = 0;
    while ((outstanding() != 0 || busy) && k < budget) begin
      tick();
      k++;
    end
    check({name, "_outstanding"}, 32'(outstanding()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    req_valid  = '0;
    req_t      = '0;
    req_negate = '0;
    rsp_ready  = '1;
    inject     = 1'b0;
    clear_logs();
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_dp_valid_in", 32'(dp_valid_in), 32'd0);
    check("rst_dp_t", dp_t, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", rsp_z[31:0] | rsp_z[63:32] | rsp_z[95:64] | rsp_z[127:96], 32'd0);
    check("rst_busy_err", {30'd0, busy, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single lane 1 request: one issue, result 14 cycles after acceptance.
    k = dp_issues;
    add_req(1, 32'h0002_0000, 1'b0);
    wait_gcnt(1, 1, 10, "t1_grant");
    drain(60, "t1");
    check("t1_issues", 32'(dp_issues - k), 32'd1);
    check("t1_rsp_count", 32'(rsp_cyc[1].size()), 32'd1);
    if (rsp_cyc[1].size() > 0 && gcyc.size() > 0) begin
      check("t1_latency", 32'(rsp_cyc[1][0] - gcyc[0]), 32'd14);
      check("t1_z", rsp_val[1][0], 32'h0002_5A5A);
    end

    // All lanes streaming: strict 0,1,2,3 rotation, one grant every cycle.
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int l = 0; l < N; l++)
        add_req(l, 32'((l + 1) * 65536 + r * 64), 1'((l + r) % 2));
    wait_total(12, 30, "t2_grants");
    for (int g = 0; g < glog.size(); g++) begin
      check($sformatf("t2_order%0d", g), 32'(glog[g]), 32'(g % 4));
      check($sformatf("t2_cycle%0d", g), 32'(gcyc[g] - gcyc[0]), 32'(g));
    end
    drain(60, "t2");
    if (rsp_val[1].size() > 0) check("t2_neg_z", rsp_val[1][0], 32'hFFFE_5A5A);

    // Lane 2 backpressured: four grants, then starved until a pop returns a credit.
    clear_logs();
    rsp_ready[2] = 1'b0;
    for (int r = 0; r < 6; r++) add_req(2, 32'h0030_0000 + 32'(r), 1'(r % 2));
    for (int r = 0; r < 3; r++) add_req(0, 32'h0040_0000 + 32'(r), 1'b0);
    wait_gcnt(2, 4, 20, "t3_four_grants");
    repeat (30) tick();
    #2;
    check("t3_lane2_grants", 32'(gcnt[2]), 32'd4);
    check("t3_lane2_stalled", 32'({req_valid[2], req_ready[2]}), 32'd2);
    check("t3_lane0_grants", 32'(gcnt[0]), 32'd3);
    check("t3_lane2_head", 32'(rsp_valid[2]), 32'd1);
    rsp_ready[2] = 1'b1;
    tick();
    rsp_ready[2] = 1'b0;
    repeat (5) tick();
    check("t3_one_more_grant", 32'(gcnt[2]), 32'd5);
    rsp_ready[2] = 1'b1;
    drain(80, "t3");
    check("t3_lane2_total", 32'(rsp_val[2].size()), 32'd6);

    // Lane 0 full FIFO, then pops overlapping with fresh grants.
    clear_logs();
    rsp_ready[0] = 1'b0;
    for (int r = 0; r < 6; r++) add_req(0, 32'h0100_0000 + 32'(r * 3), 1'(r % 2));
    wait_gcnt(0, 4, 20, "t4_four_grants");
    repeat (20) tick();
    #2;
    check("t4_full_stalled", 32'({rsp_valid[0], req_valid[0], req_ready[0]}), 32'd6);
    rsp_ready[0] = 1'b1;
    drain(80, "t4");
    check("t4_lane0_grants", 32'(gcnt[0]), 32'd6);
    check("t4_lane0_results", 32'(rsp_val[0].size()), 32'd6);

    // Reset with six tags in flight.
    clear_logs();
    for (int l = 0; l < 3; l++) begin
      add_req(l, 32'h0200_0000 + 32'(l), 1'b0);
      add_req(l, 32'h0300_0000 + 32'(l), 1'b1);
    end
    wait_total(6, 20, "t5_grants");
    repeat (2) tick();
    check("t5_busy_inflight", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_outputs", 32'({req_ready, rsp_valid, dp_valid_in, busy, err}), 32'd0);
    check("t5_rst_dp_t", dp_t, 32'd0);
    for (int i = 0; i < N; i++) exp_q[i].delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_logs();
    repeat (30) tick();
    check("t5_no_rsp", 32'(rsp_valid), 32'd0);
    check("t5_busy_after", 32'(busy), 32'd0);
    rsp_ready[0] = 1'b0;
    for (int r = 0; r < 5; r++) add_req(0, 32'h0400_0000 + 32'(r), 1'b0);
    wait_gcnt(0, 4, 20, "t5_credit_grants");
    repeat (5) tick();
    check("t5_credit_limit", 32'(gcnt[0]), 32'd4);
    rsp_ready[0] = 1'b1;
    drain(80, "t5");

    // Orphan result with no tag in flight.
    check("t6_err_before", 32'(err), 32'd0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    repeat (3) tick();
    check("t6_err", 32'(err), ExpErr);
    check("t6_no_push", 32'(rsp_valid), 32'd0);
    repeat (5) tick();
    check("t6_err_held", 32'(err), ExpErr);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
